// File: rtl/cr_xp10_decomp_be_pack_pkg.sv
// Shared types and constants for the XP10 decompression back-end byte packer.
package cr_xp10_decompPKG;

  localparam int BE_PACK_BYTES = 8;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  bytes;
    logic        eof;
  } lz_be_dp_bus_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } be_pack_state_e;

endpackage

// File: rtl/cr_xp10_decomp_be_pack_shf.sv
// Combinational 16-byte shift/merge: drops popped bytes from the bottom of the
// accumulator and appends the accepted beat directly above the residual.
module cr_xp10_decomp_be_pack_shf
  import cr_xp10_decompPKG::*;
(
  input  logic [127:0]   i_acc,
  input  logic [4:0]     i_cnt,
  input  logic [3:0]     i_pop_bytes,
  input  logic           i_accept,
  input  lz_be_dp_bus_t  i_beat,
  output logic [127:0]   o_acc_next,
  output logic [4:0]     o_cnt_next
);

  logic [4:0]   w_base;
  logic [63:0]  w_in_mask;
  logic [127:0] w_shifted;
  logic [127:0] w_append;

  // Bytes above the beat's count are zeroed so the accumulator stays clean
  // above cnt; output masking and the flush path rely on that.
  always_comb begin
    w_in_mask = '0;
    for (int i = 0; i < BE_PACK_BYTES; i++) begin
      if (4'(i) < i_beat.bytes) w_in_mask[i*8 +: 8] = 8'hFF;
    end
  end

  always_comb begin
    w_base     = i_cnt - {1'b0, i_pop_bytes};
    w_shifted  = i_acc >> {i_pop_bytes, 3'b000};
    w_append   = {64'b0, i_beat.data & w_in_mask} << {w_base, 3'b000};
    o_acc_next = w_shifted;
    o_cnt_next = w_base;
    if (i_accept) begin
      o_acc_next = w_shifted | w_append;
      o_cnt_next = w_base + {1'b0, i_beat.bytes};
    end
  end

endmodule

// File: rtl/cr_xp10_decomp_be_pack.sv
// XP10 decompression back-end packer: repacks 0..8-byte beats into dense
// 8-byte words, flushes a short eof word and reports per-frame byte totals.
module cr_xp10_decomp_be_pack
  import cr_xp10_decompPKG::*;
#(
  parameter int DW = 64,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lz_be_dp_valid,
  output logic          lz_be_dp_ready,
  input  logic [DW-1:0] lz_be_dp_data,
  input  logic [3:0]    lz_be_dp_bytes,
  input  logic          lz_be_dp_eof,
  output logic          be_dp_valid,
  input  logic          be_dp_ready,
  output logic [DW-1:0] be_dp_data,
  output logic [3:0]    be_dp_bytes,
  output logic          be_dp_eof,
  output logic [CW-1:0] be_frame_bytes,
  output logic          be_frame_done,
  output logic          be_len_err
);

  localparam logic [4:0] LP_WORD = 5'(BE_PACK_BYTES);

  be_pack_state_e r_state, w_state_next;
  logic [127:0]   r_acc;
  logic [4:0]     r_cnt;
  logic [CW-1:0]  r_run_bytes;
  logic [CW-1:0]  r_frame_bytes;
  logic           r_frame_done;
  logic           r_len_err;

  lz_be_dp_bus_t  w_beat;
  logic           w_accept;
  logic           w_pop;
  logic           w_eof_pop;
  logic [3:0]     w_pop_bytes;
  logic [127:0]   w_acc_next;
  logic [4:0]     w_cnt_next;
  logic [63:0]    w_out_mask;
  logic [CW:0]    w_run_sum;
  logic [CW-1:0]  w_run_sat;

  // Oversized beats are clamped to a full word before entering the datapath.
  assign w_beat.data  = lz_be_dp_data;
  assign w_beat.bytes = (lz_be_dp_bytes > 4'd8) ? 4'd8 : lz_be_dp_bytes;
  assign w_beat.eof   = lz_be_dp_eof;

  assign w_accept    = lz_be_dp_valid & lz_be_dp_ready;
  assign w_pop       = be_dp_valid & be_dp_ready;
  assign w_eof_pop   = w_pop & be_dp_eof;
  assign w_pop_bytes = w_pop ? be_dp_bytes : 4'd0;

  cr_xp10_decomp_be_pack_shf u_shf (
    .i_acc       (r_acc),
    .i_cnt       (r_cnt),
    .i_pop_bytes (w_pop_bytes),
    .i_accept    (w_accept),
    .i_beat      (w_beat),
    .o_acc_next  (w_acc_next),
    .o_cnt_next  (w_cnt_next)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (w_accept && lz_be_dp_eof) w_state_next = FLUSH;
      FLUSH:   if (w_eof_pop)                w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_comb begin
    lz_be_dp_ready = 1'b0;
    be_dp_valid    = 1'b0;
    be_dp_bytes    = 4'd0;
    be_dp_eof      = 1'b0;
    case (r_state)
      RUN: begin
        lz_be_dp_ready = (r_cnt <= LP_WORD);
        be_dp_valid    = (r_cnt >= LP_WORD);
        be_dp_bytes    = be_dp_valid ? 4'd8 : 4'd0;
      end
      FLUSH: begin
        be_dp_valid = 1'b1;
        be_dp_bytes = (r_cnt >= LP_WORD) ? 4'd8 : r_cnt[3:0];
        be_dp_eof   = (r_cnt <= LP_WORD);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_out_mask = '0;
    for (int i = 0; i < BE_PACK_BYTES; i++) begin
      if (4'(i) < be_dp_bytes) w_out_mask[i*8 +: 8] = 8'hFF;
    end
  end

  assign be_dp_data = DW'(r_acc[63:0] & w_out_mask);

  always_ff @(posedge clk) begin
    if (rst || w_eof_pop) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_next;
    end
  end

  // Running frame count saturates rather than wrapping on oversized frames.
  assign w_run_sum = {1'b0, r_run_bytes} + {{(CW-3){1'b0}}, w_pop_bytes};
  assign w_run_sat = w_run_sum[CW] ? {CW{1'b1}} : w_run_sum[CW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_bytes   <= '0;
      r_frame_bytes <= '0;
      r_frame_done  <= 1'b0;
      r_len_err     <= 1'b0;
    end else begin
      r_frame_done <= w_eof_pop;
      r_len_err    <= w_accept & (lz_be_dp_bytes > 4'd8);
      if (w_eof_pop) begin
        r_frame_bytes <= w_run_sat;
        r_run_bytes   <= '0;
      end else begin
        r_run_bytes <= w_run_sat;
      end
    end
  end

  assign be_frame_bytes = r_frame_bytes;
  assign be_frame_done  = r_frame_done;
  assign be_len_err     = r_len_err;

endmodule

// File: tb/tb_cr_xp10_decomp_be_pack.sv
// Directed bench for the back-end packer: streams, residual flush, zero eof,
// backpressure, length error and mid-frame reset.
module tb_cr_xp10_decomp_be_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lz_be_dp_valid = 1'b0;
  logic        lz_be_dp_ready;
  logic [63:0] lz_be_dp_data = '0;
  logic [3:0]  lz_be_dp_bytes = '0;
  logic        lz_be_dp_eof = 1'b0;
  logic        be_dp_valid;
  logic        be_dp_ready = 1'b1;
  logic [63:0] be_dp_data;
  logic [3:0]  be_dp_bytes;
  logic        be_dp_eof;
  logic [31:0] be_frame_bytes;
  logic        be_frame_done;
  logic        be_len_err;

  cr_xp10_decomp_be_pack #(.DW(64), .CW(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .lz_be_dp_valid (lz_be_dp_valid),
    .lz_be_dp_ready (lz_be_dp_ready),
    .lz_be_dp_data  (lz_be_dp_data),
    .lz_be_dp_bytes (lz_be_dp_bytes),
    .lz_be_dp_eof   (lz_be_dp_eof),
    .be_dp_valid    (be_dp_valid),
    .be_dp_ready    (be_dp_ready),
    .be_dp_data     (be_dp_data),
    .be_dp_bytes    (be_dp_bytes),
    .be_dp_eof      (be_dp_eof),
    .be_frame_bytes (be_frame_bytes),
    .be_frame_done  (be_frame_done),
    .be_len_err     (be_len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  bytes;
    logic        eof;
    int          cyc;
  } word_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          len_err_cnt = 0;
  word_t       words_q[$];
  logic [31:0] frame_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && be_dp_valid && be_dp_ready)
      words_q.push_back('{be_dp_data, be_dp_bytes, be_dp_eof, cyc});
    if (be_frame_done) frame_q.push_back(be_frame_bytes);
    if (be_len_err) len_err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] start, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = start + 8'(i);
    return v;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [63:0] d, input logic [3:0] b, input logic e);
    int t;
    t = 0;
    lz_be_dp_valid = 1'b1;
    lz_be_dp_data  = d;
    lz_be_dp_bytes = b;
    lz_be_dp_eof   = e;
    @(negedge clk);
    while (!lz_be_dp_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) chk("send_timeout", 64'(t), 64'd0);
    @(posedge clk);
    #1;
    lz_be_dp_valid = 1'b0;
    lz_be_dp_data  = '0;
    lz_be_dp_bytes = '0;
    lz_be_dp_eof   = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input logic [31:0] exp_bytes);
    int t;
    t = 0;
    while (frame_q.size() == 0 && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, "_done"}, 64'(frame_q.size()), 64'd1);
    if (frame_q.size() > 0) chk({tag, "_frame_bytes"}, 64'(frame_q[0]), 64'(exp_bytes));
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [63:0] d,
                          input logic [3:0] b, input logic e);
    if (idx < words_q.size()) begin
      chk({tag, "_data"},  words_q[idx].data, d);
      chk({tag, "_bytes"}, 64'(words_q[idx].bytes), 64'(b));
      chk({tag, "_eof"},   64'(words_q[idx].eof), 64'(e));
    end else begin
      chk({tag, "_missing"}, 64'(words_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic clear_q();
    words_q.delete();
    frame_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int le0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lz_ready",    64'(lz_be_dp_ready), 64'd1);
    chk("rst_valid",       64'(be_dp_valid),    64'd0);
    chk("rst_data",        be_dp_data,          64'd0);
    chk("rst_bytes",       64'(be_dp_bytes),    64'd0);
    chk("rst_eof",         64'(be_dp_eof),      64'd0);
    chk("rst_frame_bytes", 64'(be_frame_bytes), 64'd0);
    chk("rst_frame_done",  64'(be_frame_done),  64'd0);
    chk("rst_len_err",     64'(be_len_err),     64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full-width stream, one word per cycle.
    clear_q();
    for (int k = 0; k < 4; k++) send(mk(8'(8 * k), 8), 4'd8, k == 3);
    wait_frame("full", 32'd32);
    chk("full_nwords", 64'(words_q.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk_word("full_w", k, mk(8'(8 * k), 8), 4'd8, k == 3);
    for (int k = 1; k < 4; k++)
      if (k < words_q.size()) chk("full_tput", 64'(words_q[k].cyc - words_q[k-1].cyc), 64'd1);

    // Odd sizes with a dropped empty beat in the middle.
    clear_q();
    send(mk(8'hA0, 3), 4'd3, 1'b0);
    send(mk(8'hA3, 5), 4'd5, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b0);
    send(mk(8'hA8, 7), 4'd7, 1'b0);
    send(mk(8'hAF, 1), 4'd1, 1'b1);
    wait_frame("odd", 32'd16);
    chk("odd_nwords", 64'(words_q.size()), 64'd2);
    chk_word("odd_w0", 0, mk(8'hA0, 8), 4'd8, 1'b0);
    chk_word("odd_w1", 1, mk(8'hA8, 8), 4'd8, 1'b1);

    // Residual flush.
    clear_q();
    send(mk(8'h50, 8), 4'd8, 1'b0);
    send(mk(8'h58, 3), 4'd3, 1'b1);
    wait_frame("resid", 32'd11);
    chk("resid_nwords", 64'(words_q.size()), 64'd2);
    chk_word("resid_w0", 0, mk(8'h50, 8), 4'd8, 1'b0);
    chk_word("resid_w1", 1, 64'h0000_0000_005A_5958, 4'd3, 1'b1);

    // Zero-byte eof.
    clear_q();
    send(64'd0, 4'd0, 1'b1);
    wait_frame("zero", 32'd0);
    chk("zero_nwords", 64'(words_q.size()), 64'd1);
    chk_word("zero_w0", 0, 64'd0, 4'd0, 1'b1);

    // Backpressure: two beats fill the accumulator, third must wait.
    clear_q();
    be_dp_ready = 1'b0;
    send(mk(8'hB0, 8), 4'd8, 1'b0);
    send(mk(8'hB8, 8), 4'd8, 1'b0);
    @(negedge clk);
    chk("bp_lz_ready",  64'(lz_be_dp_ready), 64'd0);
    chk("bp_valid",     64'(be_dp_valid),    64'd1);
    chk("bp_data",      be_dp_data,          mk(8'hB0, 8));
    repeat (3) @(negedge clk);
    chk("bp_lz_ready2", 64'(lz_be_dp_ready), 64'd0);
    chk("bp_data_hold", be_dp_data,          mk(8'hB0, 8));
    chk("bp_bytes",     64'(be_dp_bytes),    64'd8);
    chk("bp_eof",       64'(be_dp_eof),      64'd0);
    chk("bp_nopop",     64'(words_q.size()), 64'd0);
    @(posedge clk);
    #1 be_dp_ready = 1'b1;
    send(mk(8'hC0, 8), 4'd8, 1'b1);
    wait_frame("bp", 32'd24);
    chk("bp_nwords", 64'(words_q.size()), 64'd3);
    chk_word("bp_w0", 0, mk(8'hB0, 8), 4'd8, 1'b0);
    chk_word("bp_w1", 1, mk(8'hB8, 8), 4'd8, 1'b0);
    chk_word("bp_w2", 2, mk(8'hC0, 8), 4'd8, 1'b1);

    // Oversized beat, then reset mid-frame.
    clear_q();
    le0 = len_err_cnt;
    send(mk(8'hD0, 8), 4'd12, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_pulses", 64'(len_err_cnt - le0), 64'd1);
    chk("err_nwords", 64'(words_q.size()), 64'd1);
    chk_word("err_w0", 0, mk(8'hD0, 8), 4'd8, 1'b0);
    be_dp_ready = 1'b0;
    send(mk(8'hE0, 8), 4'd8, 1'b0);
    send(mk(8'hE8, 4), 4'd4, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid",    64'(be_dp_valid),    64'd1);
    chk("pre_rst_lz_ready", 64'(lz_be_dp_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid",    64'(be_dp_valid),    64'd0);
    chk("post_rst_lz_ready", 64'(lz_be_dp_ready), 64'd1);
    chk("post_rst_bytes",    64'(be_dp_bytes),    64'd0);
    chk("post_rst_done",     64'(frame_q.size()), 64'd0);
    @(posedge clk);
    #1;
    clear_q();
    be_dp_ready = 1'b1;
    send(mk(8'hF0, 5), 4'd5, 1'b1);
    wait_frame("after_rst", 32'd5);
    chk("after_rst_nwords", 64'(words_q.size()), 64'd1);
    chk_word("after_rst_w0", 0, mk(8'hF0, 5), 4'd5, 1'b1);
    chk("err_total", 64'(len_err_cnt - le0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cr_xp10_decomp_be_pack.md
# cr_xp10_decomp_be_pack

Output byte packer for the XP10 decompression path. It sits directly downstream of the LZ77 reconstruction stage and consumes its variable-width back-end beats of 0–8 bytes. It repacks them into dense 8-byte words for the back end, flushes a short final word at end of frame, and reports a per-frame byte count.

## Interface
Parameters:
- `DW`, default 64: data width in bits; fixed to 8 bytes per beat.
- `CW`, default 32: width of the frame byte counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `lz_be_dp_valid`  in  1  input beat valid.
- `lz_be_dp_ready`  out  1  input beat accepted when valid & ready.
- `lz_be_dp_data`  in  64  input bytes, byte 0 = bits [7:0], packed from the LSB.
- `lz_be_dp_bytes`  in  4  number of valid bytes in the beat, 0..8.
- `lz_be_dp_eof`  in  1  last beat of the frame.
- `be_dp_valid`  out  1  output word valid.
- `be_dp_ready`  in  1  downstream accept.
- `be_dp_data`  out  64  packed output bytes, LSB first; invalid bytes are 0.
- `be_dp_bytes`  out  4  number of valid bytes in the word, 0..8.
- `be_dp_eof`  out  1  last word of the frame.
- `be_frame_bytes`  out  CW  byte total of the last completed frame.
- `be_frame_done`  out  1  one-cycle pulse on the pop of an eof word.
- `be_len_err`  out  1  one-cycle pulse when an accepted beat has bytes > 8.

## Operation
- Internal storage is a 16-byte accumulator `acc` plus a byte count `cnt`. `cnt` is 5 bits and ranges 0..16.
- State machine has two states: `RUN` and `FLUSH`.
- Input handshake:
  - `lz_be_dp_ready = (state==RUN) && (cnt <= 8)`. It is a registered-state function and never depends on `be_dp_ready`.
  - On accept, the beat's bytes are appended at byte offset `cnt`.
  - `bytes > 8` is clamped to 8, and `be_len_err` pulses.
  - A beat with `bytes = 0` and no eof is accepted and dropped, with no state change.
- Output in RUN:
  - `be_dp_valid = (cnt >= 8)`.
  - The word is `acc[7:0]`, with `be_dp_bytes = 8` and `be_dp_eof = 0`.
- Output in FLUSH:
  - `be_dp_valid = 1`.
  - `be_dp_bytes = min(cnt, 8)`.
  - `be_dp_eof = (cnt <= 8)`.
  - Bytes at or above `be_dp_bytes` are driven 0.
- Pop (`be_dp_valid & be_dp_ready`) shifts `acc` down by `be_dp_bytes` and subtracts that amount from `cnt`.
- Pop and accept in the same cycle:
  - `cnt_next = cnt - popped + min(bytes, 8)`.
  - Bytes are appended at offset `cnt - popped`.
- State transitions:
  - RUN → FLUSH when an eof beat is accepted.
  - FLUSH → RUN on the pop of the eof word, and `cnt` becomes 0.
- Zero-byte eof, or eof with an empty residual: one word is emitted with `be_dp_bytes = 0` and `be_dp_eof = 1`. Every frame produces exactly one eof word.
- Frame counter:
  - An internal running count adds popped bytes and saturates at 2^CW−1.
  - On the eof pop, the running count plus the eof word's bytes is loaded into `be_frame_bytes`, the running count clears, and `be_frame_done` pulses.

## Timing
- Reset values:
  - State RUN, `cnt = 0`, `acc = 0`.
  - `lz_be_dp_ready = 1`, `be_dp_valid = 0`, `be_dp_data = 0`, `be_dp_bytes = 0`, `be_dp_eof = 0`.
  - `be_frame_bytes = 0`, `be_frame_done = 0`, `be_len_err = 0`.
- Reset mid-frame discards the accumulator and the running count. No eof word is emitted.
- Latency: bytes accepted in cycle N are visible on `be_dp_*` no earlier than cycle N+1.
- Throughput: a continuous stream of 8-byte beats with `be_dp_ready = 1` sustains one word per cycle. The `cnt = 8` case accepts and pops simultaneously.
- Backpressure: with `be_dp_ready = 0`, at most 16 bytes are buffered. At `cnt > 8`, `lz_be_dp_ready` drops the next cycle.
- Output stability: `be_dp_data`, `be_dp_bytes` and `be_dp_eof` are held stable while `be_dp_valid & !be_dp_ready`.
- `be_frame_done` and `be_len_err` are registered pulses, asserted the cycle after the triggering event.

## Structure
- `cr_xp10_decompPKG` holds:
  - the `lz_be_dp_bus_t` struct (data / bytes / eof);
  - the `be_pack_state_e` enum (RUN, FLUSH);
  - the localparam `BE_PACK_BYTES = 8`.
- One sub-module, `cr_xp10_decomp_be_pack_shf`: a combinational 16-byte shift and merge that takes `acc`, `cnt`, the popped count and the input beat, and produces `acc_next` and `cnt_next`. All registers live in the parent.

## Test plan
- **Full-width stream.** Send 4 beats of 8 bytes (0x00..0x1F) with eof on beat 4, `be_dp_ready = 1`.
  - Expect 4 words, one per cycle, the last with `eof = 1` and `bytes = 8`.
  - Expect `be_frame_bytes = 32`.
- **Odd sizes.** Send beats of 3, 5, 7 and 1 bytes, eof on the last.
  - Expect words of bytes 8 then 8, the second with `eof = 1`.
  - Expect data contiguous and LSB-first.
- **Residual flush.** Send beats of 8 and 3 bytes (eof).
  - Expect words of 8 then 3 (`eof = 1`), with upper 5 bytes zero.
  - Expect `be_frame_bytes = 11`.
- **Zero-byte eof.** Send a single beat with `bytes = 0`, eof.
  - Expect one word with `bytes = 0`, `eof = 1`.
  - Expect `be_frame_bytes = 0` and a `be_frame_done` pulse.
- **Backpressure.** Hold `be_dp_ready = 0` while sending 8-byte beats.
  - Expect `lz_be_dp_ready` low after 2 accepts (`cnt = 16`).
  - Expect `be_dp_*` to stay stable.
  - After release, expect no data loss or reorder.
- **Error and reset.** Send a beat with `bytes = 12`.
  - Expect it treated as 8 and `be_len_err` to pulse once.
  - Assert `rst` mid-frame: next cycle `be_dp_valid = 0` and `lz_be_dp_ready = 1`.
  - Expect the following frame to count from 0.
